// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg: instruction word layout, opcodes, fault codes and sequencer states
package i2c_seq_pkg;
  typedef struct packed {
    logic [7:0] op;
    logic [7:0] dev;
    logic [7:0] regad;
    logic [7:0] data;
  } instr_t;
  typedef enum logic [7:0] {OP_NOP = 8'h00, OP_RD = 8'h01, OP_WR = 8'h02} opcode_t;
  localparam logic [3:0] FC_ROM = 4'd1;
  localparam logic [3:0] FC_OPCODE = 4'd2;
  localparam logic [3:0] FC_NACK = 4'd3;
  localparam logic [3:0] FC_TIMEOUT = 4'd4;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, ISSUE, RESP, NEXT, FAULT} state_t;
endpackage

// File: rtl/i2c_instr_sequencer.sv
// i2c_instr_sequencer: steps the instruction ROM, decodes each word and issues I2C commands
module i2c_instr_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int PROG_LEN    = 4,
  parameter int LOOP_START  = 2,
  parameter int RSP_TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [31:0]       instr_data,
  input  logic [3:0]        instr_err,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_rw,
  output logic [6:0]        cmd_dev,
  output logic [7:0]        cmd_reg,
  output logic [7:0]        cmd_wdata,
  input  logic              rsp_valid,
  input  logic              rsp_nack,
  input  logic [7:0]        rsp_data,
  output logic              rd_valid,
  output logic [7:0]        rd_reg,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic              fault,
  output logic [3:0]        fault_code
);
  localparam int CNT_W = $clog2(RSP_TIMEOUT + 1);
  state_t state, state_n;
  instr_t instr;
  logic [CNT_W-1:0] cnt;
  logic [3:0] code_n;
  logic op_ok, timed_out, unused_dev;
  assign instr = instr_t'(instr_data);
  assign unused_dev = instr.dev[7];
  assign op_ok = instr.op == OP_RD || instr.op == OP_WR;
  assign timed_out = cnt == CNT_W'(RSP_TIMEOUT);
  assign cmd_valid = state == ISSUE;
  assign busy = state != IDLE && state != FAULT;
  assign fault = state == FAULT;
  // a response arriving in the timeout cycle takes priority over the timeout
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? FETCH : IDLE;
      FETCH:   state_n = DECODE;
      DECODE:  state_n = instr_err != '0 ? FAULT : instr.op == OP_NOP ? NEXT : op_ok ? ISSUE : FAULT;
      ISSUE:   state_n = cmd_ready ? RESP : ISSUE;
      RESP:    state_n = rsp_valid ? (rsp_nack ? FAULT : NEXT) : timed_out ? FAULT : RESP;
      NEXT:    state_n = stop ? IDLE : FETCH;
      default: state_n = FAULT;
    endcase
  end
  assign code_n = state == DECODE ? (instr_err != '0 ? FC_ROM : FC_OPCODE) : rsp_valid ? FC_NACK : FC_TIMEOUT;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      instr_addr <= '0;
      cmd_rw <= 1'b0;
      cmd_dev <= '0;
      cmd_reg <= '0;
      cmd_wdata <= '0;
      rd_valid <= 1'b0;
      rd_reg <= '0;
      rd_data <= '0;
      fault_code <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      rd_valid <= state == RESP && rsp_valid && !rsp_nack && cmd_rw;
      cnt <= state != RESP ? '0 : timed_out ? cnt : cnt + 1'b1;
      if (state == IDLE && start) instr_addr <= '0;
      if (state == NEXT)
        instr_addr <= stop ? '0 : instr_addr == ADDR_W'(PROG_LEN - 1) ? ADDR_W'(LOOP_START) : instr_addr + 1'b1;
      if (state == DECODE && state_n == ISSUE) begin
        cmd_rw <= instr.op == OP_RD;
        cmd_dev <= instr.dev[6:0];
        cmd_reg <= instr.regad;
        cmd_wdata <= instr.op == OP_RD ? 8'h00 : instr.data;
      end
      if (state == RESP && rsp_valid && !rsp_nack && cmd_rw) begin
        rd_reg <= cmd_reg;
        rd_data <= rsp_data;
      end
      if (state_n == FAULT && state != FAULT) fault_code <= code_n;
    end
  end
endmodule
